// File: rtl/ascii_string_streamer_if.sv
// Byte-stream handshake bundle for the ASCII string streamer.
// The streamer takes the slave side; the string source and byte sink take the master side.
interface ascii_string_streamer_if #(
   parameter int MAX_CHARS = 16
);
   logic                   load_valid;
   logic                   load_ready;
   logic [8*MAX_CHARS-1:0] str_in;
   logic [7:0]             out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   busy;
   logic                   done;

   modport slave (
      input  load_valid, str_in, out_ready,
      output load_ready, out_data, out_valid, busy, done
   );

   modport master (
      output load_valid, str_in, out_ready,
      input  load_ready, out_data, out_valid, busy, done
   );
endinterface

// File: rtl/ascii_string_streamer.sv
// Streams a captured ASCII string one byte per beat, lane 0 first,
// stopping at the first NUL and optionally appending CR/LF.
module ascii_string_streamer #(
   parameter int MAX_CHARS      = 16,
   parameter int APPEND_NEWLINE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ascii_string_streamer_if.slave bus
);
   localparam int IW = $clog2(MAX_CHARS) + 1;
   localparam int SW = 8 * MAX_CHARS;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      CR,
      LF,
      DONE
   } state_t;

   state_t        state, state_d;
   logic [IW-1:0] idx, idx_d, nxt;
   logic [SW-1:0] str_q, str_d;
   logic [SW-1:0] sh_cur, sh_nxt;
   logic [7:0]    cur, nxt_lane;
   logic          zero_sub, last, xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         str_q <= '0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         str_q <= str_d;
      end
   end

   // Shifting keeps the lane lookup in range when nxt reaches MAX_CHARS.
   always_comb begin
      sh_cur   = str_q >> {idx, 3'b000};
      nxt      = idx + IW'(1);
      sh_nxt   = str_q >> {nxt, 3'b000};
      cur      = sh_cur[7:0];
      nxt_lane = sh_nxt[7:0];
      zero_sub = (idx == '0) && (cur == 8'h00);
      last     = (nxt == IW'(MAX_CHARS)) ||
                 (nxt_lane == 8'h00) || zero_sub;
   end

   always_comb begin
      state_d        = state;
      idx_d          = idx;
      str_d          = str_q;
      bus.load_ready = 1'b0;
      bus.out_valid  = 1'b0;
      bus.out_data   = 8'h00;
      bus.busy       = 1'b1;
      bus.done       = 1'b0;
      xfer           = 1'b0;
      unique case (state)
         IDLE: begin
            bus.load_ready = 1'b1;
            bus.busy       = 1'b0;
            if (bus.load_valid) begin
               str_d   = bus.str_in;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            bus.out_valid = 1'b1;
            bus.out_data  = zero_sub ? 8'h30 : cur;
            xfer          = bus.out_ready;
            if (xfer) begin
               idx_d = nxt;
               if (last)
                  state_d = (APPEND_NEWLINE != 0) ? CR : DONE;
            end
         end
         CR: begin
            bus.out_valid = 1'b1;
            bus.out_data  = 8'h0D;
            xfer          = bus.out_ready;
            if (xfer) state_d = LF;
         end
         LF: begin
            bus.out_valid = 1'b1;
            bus.out_data  = 8'h0A;
            xfer          = bus.out_ready;
            if (xfer) state_d = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: doc/ascii_string_streamer.md
# ascii_string_streamer

Downstream stage of the decimal-to-base converter: accepts the 128-bit ASCII digit string the converter produces and streams it out one byte per beat over a valid/ready byte interface, e.g. toward a UART transmitter or log buffer. Byte lane 0 holds the most-significant digit and is sent first. Streaming stops at the first NUL byte, then an optional CR/LF terminator is sent. An empty string is sent as a single "0".

## Interface
- `MAX_CHARS`, default 16: number of byte lanes in `str_in`; the upper bound on the characters sent from one string.
- `APPEND_NEWLINE`, default 1: when 1, send 0x0D then 0x0A after the last character; when 0, send no terminator.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `load_valid` input, 1 bit: `str_in` holds a string to be sent.
- `load_ready` output, 1 bit: block is idle and will accept a string.
- `str_in` input, 8*MAX_CHARS bits: ASCII string; lane k is `[8k+7:8k]`, and lane 0 is sent first.
- `out_data` output, 8 bits: current byte.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_ready` input, 1 bit: the sink accepts the byte.
- `busy` output, 1 bit: a string is in progress, from capture until `done`.
- `done` output, 1 bit: one-cycle pulse after the final byte has been transferred.

## Operation
- States: IDLE, SEND, CR, LF, DONE.
- IDLE:
  - `load_ready`=1; all other outputs are 0.
  - On `load_valid && load_ready`, capture `str_in` into an internal register, clear the lane index `idx`, and go to SEND.
- SEND:
  - `out_valid`=1.
  - `out_data` = lane `idx`, except that when `idx`==0 and lane 0 is 0x00, `out_data` = 0x30 ("0").
  - On a transfer (`out_valid && out_ready`), increment `idx`.
  - The string ends after the current byte when the next index equals MAX_CHARS or the next lane is 0x00. At the end, go to CR if APPEND_NEWLINE=1, otherwise go to DONE.
  - The substituted "0" also ends the string.
- CR: present 0x0D; after transfer go to LF.
- LF: present 0x0A; after transfer go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Bytes after the first NUL are never sent, even if they are non-zero.
- `idx` width is clog2(MAX_CHARS)+1 so that it can count to MAX_CHARS without wrap-around.
- `busy` = 1 in SEND, CR, LF and DONE.
- `load_ready` = 1 in IDLE only. `load_valid` in any other state is ignored and no data is captured.

## Timing
- Reset values: `load_ready`=1, `out_valid`=0, `out_data`=0x00, `busy`=0, `done`=0, state IDLE, `idx`=0, capture register all zeros.
- Reset mid-string aborts the string immediately with no further bytes and no `done`. The first edge after release is in IDLE.
- All outputs are registered or decoded from registered state. `out_data` and `out_valid` have no combinational path from `out_ready` or `load_valid`.
- Latency: string accepted at edge N gives `out_valid`=1 in the cycle after edge N with the first byte.
- With `out_ready` held high, one byte transfers per cycle.
- For n characters plus terminator, the bytes occupy cycles N+1 … N+n+2, `done` is in cycle N+n+3, and the next load is accepted at the edge ending cycle N+n+4.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable. `out_valid` never drops before its byte transfers.
- `out_ready` high outside SEND/CR/LF has no effect.
- `str_in` changes after capture do not affect the string in flight.

## Test plan
- Reset, then load lanes 0..1 = "1","A" with the rest 0, `out_ready`=1 → bytes 0x31, 0x41, 0x0D, 0x0A on consecutive cycles; `done` pulses one cycle later; `load_ready` returns to 1 the cycle after `done`.
- Load all-zero `str_in` → bytes 0x30, 0x0D, 0x0A, then `done`.
- Load 16 non-zero lanes "0123456789ABCDEF" → all 16 bytes in lane order, then CR/LF. No index wrap and no 17th byte.
- Load "7", NUL, "5" (lanes 0..2) with `out_ready` toggling 1,0,0,1,… → only 0x37, 0x0D, 0x0A are sent. `out_data` stays stable during every stall. No bytes are lost or repeated.
- Pulse `load_valid` with a different string while the first string is in SEND → ignored, and the first string completes unchanged. Separately, assert `rst_n`=0 mid-string → outputs return to their reset values immediately, and there is no `done`.
- With APPEND_NEWLINE=0, load "10" → only 0x31, 0x30, then `done` in the next cycle.
